// File: rtl/cache_controller_wb_if.sv
// Bus bundle of the write-back cache: CPU load/store port, memory beat bus
// and the hit/miss statistics. The cache itself is the slave side.
interface cache_controller_wb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [15:0]       hit_count;
  logic [15:0]       miss_count;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata,
           hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata,
           hit_count, miss_count
  );
endinterface

// File: rtl/cache_controller_wb.sv
// Write-back, write-allocate, N-way set-associative cache controller with
// dirty-victim writeback, multi-beat refill and saturating hit/miss counters.
module cache_controller_wb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int WORDS  = 4
) (
  input logic                 clk,
  input logic                 reset,
  cache_controller_wb_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] FIRST_BEAT = {OFF_W{1'b0}};
  localparam logic [OFF_W-1:0] LAST_BEAT  = OFF_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_FILL      = 3'd3,
    S_RESP      = 3'd4
  } state_e;

  state_e            state_q;
  logic              we_q;
  logic              first_q;
  logic              all_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WAY_W-1:0]  victim_q;
  logic [OFF_W-1:0]  beat_q;

  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS];

  logic [DATA_W-1:0] cpu_rdata_q;
  logic              cpu_ready_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [15:0]       hit_cnt_q;
  logic [15:0]       miss_cnt_q;

  logic [TAG_W-1:0]  tag_a;
  logic [IDX_W-1:0]  idx_a;
  logic [OFF_W-1:0]  off_a;
  logic              hit_d;
  logic [WAY_W-1:0]  hit_way_d;
  logic [WAY_W-1:0]  victim_d;
  logic              all_valid_d;
  logic [OFF_W-1:0]  beat_nx_d;
  logic              last_beat_d;
  logic              ack_d;

  assign tag_a       = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_a       = addr_q[OFF_W +: IDX_W];
  assign off_a       = addr_q[OFF_W-1:0];
  assign beat_nx_d   = beat_q + 1'b1;
  assign last_beat_d = (beat_q == LAST_BEAT);
  assign ack_d       = bus.mem_ack & mem_req_q;

  // Tag compare across all valid ways of the captured set.
  always_comb begin
    hit_d     = 1'b0;
    hit_way_d = {WAY_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_a][w] && (tag_q[idx_a][w] == tag_a)) begin
        hit_d     = 1'b1;
        hit_way_d = WAY_W'(w);
      end else begin
        hit_d     = hit_d;
        hit_way_d = hit_way_d;
      end
    end
  end

  // Victim choice: lowest invalid way wins, else the set's round-robin pointer.
  always_comb begin
    all_valid_d = 1'b1;
    victim_d    = rr_q[idx_a];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx_a][w]) begin
        all_valid_d = 1'b0;
        victim_d    = WAY_W'(w);
      end else begin
        all_valid_d = all_valid_d;
        victim_d    = victim_d;
      end
    end
  end

  // Control FSM with line bookkeeping, statistics and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      first_q     <= 1'b0;
      all_valid_q <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      victim_q    <= {WAY_W{1'b0}};
      beat_q      <= FIRST_BEAT;
      cpu_rdata_q <= {DATA_W{1'b0}};
      cpu_ready_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      hit_cnt_q   <= 16'h0000;
      miss_cnt_q  <= 16'h0000;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= {WAY_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cpu_req) begin
            we_q    <= bus.cpu_we;
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            first_q <= 1'b1;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          // Only the first lookup of a request is a statistic; the replay is not.
          if (first_q) begin
            if (hit_d) begin
              if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
              if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
          end
          first_q <= 1'b0;
          if (hit_d) begin
            if (we_q) begin
              dirty_q[idx_a][hit_way_d] <= 1'b1;
            end else begin
              cpu_rdata_q <= data_q[idx_a][hit_way_d][off_a];
            end
            cpu_ready_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            victim_q    <= victim_d;
            all_valid_q <= all_valid_d;
            beat_q      <= FIRST_BEAT;
            mem_req_q   <= 1'b1;
            if (valid_q[idx_a][victim_d] && dirty_q[idx_a][victim_d]) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {tag_q[idx_a][victim_d], idx_a, FIRST_BEAT};
              mem_wdata_q <= data_q[idx_a][victim_d][FIRST_BEAT];
              state_q     <= S_WRITEBACK;
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag_a, idx_a, FIRST_BEAT};
              state_q    <= S_FILL;
            end
          end
        end
        S_WRITEBACK: begin
          if (ack_d) begin
            if (last_beat_d) begin
              dirty_q[idx_a][victim_q] <= 1'b0;
              beat_q     <= FIRST_BEAT;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag_a, idx_a, FIRST_BEAT};
              state_q    <= S_FILL;
            end else begin
              beat_q      <= beat_nx_d;
              mem_addr_q  <= {tag_q[idx_a][victim_q], idx_a, beat_nx_d};
              mem_wdata_q <= data_q[idx_a][victim_q][beat_nx_d];
            end
          end
        end
        S_FILL: begin
          if (ack_d) begin
            if (last_beat_d) begin
              mem_req_q                <= 1'b0;
              valid_q[idx_a][victim_q] <= 1'b1;
              dirty_q[idx_a][victim_q] <= 1'b0;
              if (all_valid_q) rr_q[idx_a] <= rr_q[idx_a] + 1'b1;
              beat_q  <= FIRST_BEAT;
              state_q <= S_LOOKUP;
            end else begin
              beat_q     <= beat_nx_d;
              mem_addr_q <= {tag_a, idx_a, beat_nx_d};
            end
          end
        end
        S_RESP: begin
          cpu_ready_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          cpu_ready_q <= 1'b0;
          mem_req_q   <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // Line storage: write merge on a hit and refill beats; tag set on the last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      if ((state_q == S_LOOKUP) && hit_d && we_q) begin
        data_q[idx_a][hit_way_d][off_a] <= wdata_q;
      end
      if ((state_q == S_FILL) && ack_d) begin
        data_q[idx_a][victim_q][beat_q] <= bus.mem_rdata;
        if (last_beat_d) tag_q[idx_a][victim_q] <= tag_a;
      end
    end
  end

  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_ready  = cpu_ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_cache_controller_wb.sv
// Scoreboard bench for cache_controller_wb: expected beats and responses are
// queued at issue time; a memory model and a CPU monitor pop and compare.
module tb_cache_controller_wb;
  logic clk;
  logic reset;

  cache_controller_wb_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  cache_controller_wb #(
    .ADDR_W(16), .DATA_W(32), .SETS(16), .WAYS(2), .WORDS(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic [15:0] hits;
    logic [15:0] misses;
    int          lat;
    longint      t_req;
  } rsp_t;

  beat_t       exp_beat_q[$];
  rsp_t        exp_rsp_q[$];
  int          total = 0;
  int          bad = 0;
  int          ack_delay = 0;
  int          nbeats = 0;
  int          wait_cnt = 0;
  logic [15:0] st_addr;
  logic [31:0] st_wdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
    beat_t b;
    b.we = we; b.addr = addr; b.wdata = wdata;
    exp_beat_q.push_back(b);
  endtask

  task automatic exp_fill(input logic [15:0] base);
    for (int i = 0; i < 4; i++) push_beat(1'b0, base + 16'(i), 32'h0);
  endtask

  // Writeback of the tag-1 line of set 0 after 0x0042 was overwritten.
  task automatic exp_wb_dirty();
    push_beat(1'b1, 16'h0040, 32'hA000_0040);
    push_beat(1'b1, 16'h0041, 32'hA000_0041);
    push_beat(1'b1, 16'h0042, 32'hDEAD_BEEF);
    push_beat(1'b1, 16'h0043, 32'hA000_0043);
  endtask

  task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic [15:0] hits,
                       input logic [15:0] misses, input int lat);
    rsp_t r;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    r.rdata = rdata; r.hits = hits; r.misses = misses; r.lat = lat; r.t_req = $time;
    exp_rsp_q.push_back(r);
    @(negedge clk);
    bus.cpu_req = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_rsp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("pending_responses", exp_rsp_q.size(), 32'd0);
    chk("pending_beats", exp_beat_q.size(), 32'd0);
    exp_rsp_q.delete();
    exp_beat_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_rsp_q.delete();
    exp_beat_q.delete();
  endtask

  // Memory model: returns 0xA0000000+addr, optional ack delay, checks every beat.
  initial begin
    beat_t e;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        if (wait_cnt == 0) begin
          st_addr  = bus.mem_addr;
          st_wdata = bus.mem_wdata;
        end
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
          bus.mem_ack = 1'b0;
        end else begin
          if (ack_delay > 0) begin
            chk("stable_mem_addr", bus.mem_addr, st_addr);
            chk("stable_mem_wdata", bus.mem_wdata, st_wdata);
          end
          if (exp_beat_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat actual_addr=%h expected=none", bus.mem_addr);
          end else begin
            e = exp_beat_q.pop_front();
            chk("beat_we", bus.mem_we, e.we);
            chk("beat_addr", bus.mem_addr, e.addr);
            if (e.we) chk("beat_wdata", bus.mem_wdata, e.wdata);
          end
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = 32'hA000_0000 + {16'h0000, bus.mem_addr};
          wait_cnt      = 0;
          nbeats++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt    = 0;
      end
    end
  end

  // CPU monitor: each ready pulse must match the oldest queued response.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (bus.cpu_ready === 1'b1) begin
        if (exp_rsp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready actual=1 expected=0");
        end else begin
          r = exp_rsp_q.pop_front();
          chk("cpu_rdata", bus.cpu_rdata, r.rdata);
          chk("hit_count", {16'h0, bus.hit_count}, {16'h0, r.hits});
          chk("miss_count", {16'h0, bus.miss_count}, {16'h0, r.misses});
          if (r.lat >= 0) chk("latency", 32'(($time - r.t_req) / 10), r.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0;
    bus.cpu_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", bus.cpu_ready, 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_mem_req", bus.mem_req, 32'd0);
    chk("rst_mem_we", bus.mem_we, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_hits", bus.hit_count, 32'd0);
    chk("rst_misses", bus.miss_count, 32'd0);
    reset = 1'b1;

    // Cold miss then a hit in the same line.
    exp_fill(16'h0040);
    issue(1'b0, 16'h0041, 32'h0, 32'hA000_0041, 16'd0, 16'd1, 7);
    wait_done();
    issue(1'b0, 16'h0043, 32'h0, 32'hA000_0043, 16'd1, 16'd1, 2);
    wait_done();

    // Write hit leaves cpu_rdata alone; read-back hit returns the new word.
    issue(1'b1, 16'h0042, 32'hDEAD_BEEF, 32'hA000_0043, 16'd2, 16'd1, 2);
    wait_done();
    issue(1'b0, 16'h0042, 32'h0, 32'hDEAD_BEEF, 16'd3, 16'd1, 2);
    wait_done();

    // Fill the second way, then evict the dirty way 0.
    exp_fill(16'h0080);
    issue(1'b0, 16'h0080, 32'h0, 32'hA000_0080, 16'd3, 16'd2, 7);
    wait_done();
    exp_wb_dirty();
    exp_fill(16'h00C0);
    issue(1'b0, 16'h00C0, 32'h0, 32'hA000_00C0, 16'd3, 16'd3, 11);
    wait_done();

    // Same eviction with every ack delayed by three cycles.
    do_reset();
    ack_delay = 3;
    exp_fill(16'h0040);
    issue(1'b0, 16'h0041, 32'h0, 32'hA000_0041, 16'd0, 16'd1, -1);
    wait_done();
    issue(1'b1, 16'h0042, 32'hDEAD_BEEF, 32'hA000_0041, 16'd1, 16'd1, -1);
    wait_done();
    exp_fill(16'h0080);
    issue(1'b0, 16'h0080, 32'h0, 32'hA000_0080, 16'd1, 16'd2, -1);
    wait_done();
    exp_wb_dirty();
    exp_fill(16'h00C0);
    issue(1'b0, 16'h00C0, 32'h0, 32'hA000_00C0, 16'd1, 16'd3, -1);
    wait_done();
    ack_delay = 0;

    // Reset while fill beat 2 is on the bus.
    do_reset();
    exp_fill(16'h0040);
    nbeats = 0;
    issue(1'b0, 16'h0041, 32'h0, 32'hA000_0041, 16'd0, 16'd1, 7);
    n = 0;
    while (nbeats < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("reached_beat2", nbeats, 32'd2);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_mem_req", bus.mem_req, 32'd0);
    chk("abort_cpu_ready", bus.cpu_ready, 32'd0);
    chk("abort_hits", bus.hit_count, 32'd0);
    chk("abort_misses", bus.miss_count, 32'd0);
    reset = 1'b1;
    exp_rsp_q.delete();
    exp_beat_q.delete();

    // Re-read misses again; a request pulsed during its fill is ignored.
    exp_fill(16'h0040);
    nbeats = 0;
    issue(1'b0, 16'h0041, 32'h0, 32'hA000_0041, 16'd0, 16'd1, 7);
    n = 0;
    while (nbeats < 1 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'h0081;
    bus.cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    issue(1'b0, 16'h0043, 32'h0, 32'hA000_0043, 16'd1, 16'd1, 2);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
